mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Read-side initiator for the data memory.
- Walks a block of word-aligned addresses, issues word reads on the memory read port (r_addr / r_en / r_addressing) and captures the returned data.
- Serialises each word into a valid/ready byte stream, MSB byte first.
- Sits between the data memory and the debug UART transmitter; used to dump memory contents to the host.

Parameters:
- NB_DATA, 32: memory word width in bits; must be a multiple of NB_BYTE.
- NB_BYTE, 8: width of one output stream symbol.
- NB_ADDRESS, 6: memory byte-address width.
- NB_COUNT, 5: width of the word-count input.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request to start a dump; ignored unless idle.
- i_base_addr  in  NB_ADDRESS  first byte address; bits [1:0] forced to 0 when latched.
- i_word_count  in  NB_COUNT  number of words to dump; 0 is legal.
- o_mem_r_addr  out  NB_ADDRESS  memory read address.
- o_mem_r_en  out  1  memory read enable.
- o_mem_r_addressing  out  2  read addressing mode; constant 2'b00 (word).
- i_mem_r_data  in  NB_DATA  memory read data; valid the cycle after o_mem_r_en.
- o_tx_data  out  NB_BYTE  stream byte.
- o_tx_valid  out  1  stream byte valid.
- i_tx_ready  in  1  downstream accepts the byte when valid && ready at a clock edge.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse at the end of a dump.

Behaviour:
- Reset:
  - Asynchronous, active-low; the clock and reset are fixed as above.
  - State = IDLE; all outputs = 0 except o_mem_r_addressing = 2'b00.
  - Internal address, counters and shift register cleared.
- Reset mid-dump: the dump is abandoned immediately; there is no resume.
- States: IDLE, REQ, WAIT, SEND, FINISH.
- IDLE:
  - On i_start, latch the base address (aligned) and the word count.
  - If the count is 0, go to FINISH; otherwise go to REQ.
  - i_start in any other state is ignored.
- REQ (one cycle): o_mem_r_en=1, o_mem_r_addr = current address; then WAIT.
- WAIT (one cycle):
  - o_mem_r_en=0.
  - Load i_mem_r_data into the shift register at the end of the cycle.
  - Byte index := 0; then SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = shift[NB_DATA-1 -: NB_BYTE].
  - On valid && ready: shift left by NB_BYTE, index+1.
  - o_tx_data must hold stable while valid && !ready.
- Last byte of a word accepted:
  - Address += 4 (modulo 2^NB_ADDRESS, wraps to 0).
  - Remaining words -= 1.
  - If remaining > 0, go to REQ; else go to FINISH.
- FINISH (one cycle): o_done=1, o_tx_valid=0; then IDLE.
- Latency: i_start sampled at edge k → REQ in cycle k+1 → WAIT in k+2 → first o_tx_valid in k+3.
- With i_tx_ready held high, each word takes NB_DATA/NB_BYTE + 2 cycles.
- o_busy is combinational from the state (state != IDLE); it is 1 during FINISH.
- Throughout, o_mem_r_en is asserted only in REQ; the block never drives a write.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined:
  - After the last data byte, add a state CSUM before FINISH.
  - CSUM presents one extra byte = XOR of every data byte sent in this dump, with the same valid/ready rules.
  - With word count 0, the checksum byte 0x00 is still sent.
  - The XOR accumulator clears on start and on reset.
- Not defined: no CSUM state; the stream ends after the last data byte.

Test Plan:
- Reset/idle: hold i_rst_n=0 for 3 cycles, release → o_busy=0, o_tx_valid=0, o_mem_r_en=0, o_done=0.
- Single word, ready=1:
  - Setup: mem[0]=32'h0123abcd, base=0, count=1, i_start pulse at edge k.
  - o_mem_r_en=1 with addr 0 in cycle k+1.
  - Bytes 01, 23, AB, CD in cycles k+3..k+6.
  - o_done in k+7.
- Backpressure: same setup, i_tx_ready toggled 1,0,0,1,... → exactly 4 bytes 01 23 AB CD, each held stable while not ready, no byte duplicated or lost.
- Multi-word wrap:
  - Setup: base=6'h3A (latched as 6'h38), count=3.
  - Read addresses 0x38, 0x3C, 0x00 in order.
  - 12 bytes sent, one o_done pulse.
- Zero count and ignored start:
  - count=0 → o_done one cycle after start, no read issued, no byte sent.
  - i_start pulsed during SEND → no effect on the stream.
- Checksum (MEM_DUMP_CHECKSUM_EN defined): single-word test above → 5th byte = 0x01^0x23^0xAB^0xCD = 0x44, then o_done.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Memory dump reader: reads a block of words and streams them out MSB byte first.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte to every dump.
module mem_dump_reader #(
    parameter int NB_DATA    = 32,
    parameter int NB_BYTE    = 8,
    parameter int NB_ADDRESS = 6,
    parameter int NB_COUNT   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [NB_ADDRESS-1:0] i_base_addr,
    input  logic [NB_COUNT-1:0]   i_word_count,
    output logic [NB_ADDRESS-1:0] o_mem_r_addr,
    output logic                  o_mem_r_en,
    output logic [1:0]            o_mem_r_addressing,
    input  logic [NB_DATA-1:0]    i_mem_r_data,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NB_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FINISH
    } state_t;

`ifdef MEM_DUMP_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_FINISH;
`endif

    state_t                state;
    state_t                state_nxt;
    logic [NB_ADDRESS-1:0] addr;
    logic [NB_COUNT-1:0]   remaining;
    logic [NB_DATA-1:0]    shift;
    logic [NB_IDX-1:0]     idx;
    logic                  mem_r_en;
    logic                  tx_valid;
    logic [NB_BYTE-1:0]    tx_data;
    logic                  done;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]    csum;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_r_en  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_word_count == '0) ? ST_TAIL : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_r_en  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: state_nxt = ST_SEND;
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift[NB_DATA-1 -: NB_BYTE];
                if (i_tx_ready && idx == LAST_IDX) begin
                    state_nxt = (remaining == NB_COUNT'(1)) ? ST_TAIL : ST_REQ;
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (i_tx_ready) begin
                    state_nxt = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address wraps naturally at 2^NB_ADDRESS.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr      <= '0;
            remaining <= '0;
            shift     <= '0;
            idx       <= '0;
        end else begin
            if (state == ST_IDLE && i_start) begin
                addr      <= {i_base_addr[NB_ADDRESS-1:2], 2'b00};
                remaining <= i_word_count;
            end
            if (state == ST_WAIT) begin
                shift <= i_mem_r_data;
                idx   <= '0;
            end
            if (state == ST_SEND && i_tx_ready) begin
                shift <= shift << NB_BYTE;
                idx   <= idx + NB_IDX'(1);
                if (idx == LAST_IDX) begin
                    addr      <= addr + NB_ADDRESS'(4);
                    remaining <= remaining - NB_COUNT'(1);
                end
            end
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            csum <= '0;
        end else if (state == ST_IDLE && i_start) begin
            csum <= '0;
        end else if (state == ST_SEND && i_tx_ready) begin
            csum <= csum ^ shift[NB_DATA-1 -: NB_BYTE];
        end
    end
`endif

    assign o_mem_r_addr       = addr;
    assign o_mem_r_en         = mem_r_en;
    assign o_mem_r_addressing = 2'b00;
    assign o_tx_data          = tx_data;
    assign o_tx_valid         = tx_valid;
    assign o_busy             = (state != ST_IDLE);
    assign o_done             = done;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Testbench for mem_dump_reader: word-array memory model and a byte-stream
// reference built directly from the dump rules.
module tb_mem_dump_reader;

    localparam int NB_DATA    = 32;
    localparam int NB_BYTE    = 8;
    localparam int NB_ADDRESS = 6;
    localparam int NB_COUNT   = 5;
    localparam int LIMIT      = 2000;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    logic                  i_clk;
    logic                  i_rst_n;
    logic                  i_start;
    logic [NB_ADDRESS-1:0] i_base_addr;
    logic [NB_COUNT-1:0]   i_word_count;
    logic [NB_ADDRESS-1:0] o_mem_r_addr;
    logic                  o_mem_r_en;
    logic [1:0]            o_mem_r_addressing;
    logic [NB_DATA-1:0]    i_mem_r_data;
    logic [NB_BYTE-1:0]    o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_busy;
    logic                  o_done;

    mem_dump_reader #(
        .NB_DATA    (NB_DATA),
        .NB_BYTE    (NB_BYTE),
        .NB_ADDRESS (NB_ADDRESS),
        .NB_COUNT   (NB_COUNT)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start            (i_start),
        .i_base_addr        (i_base_addr),
        .i_word_count       (i_word_count),
        .o_mem_r_addr       (o_mem_r_addr),
        .o_mem_r_en         (o_mem_r_en),
        .o_mem_r_addressing (o_mem_r_addressing),
        .i_mem_r_data       (i_mem_r_data),
        .o_tx_data          (o_tx_data),
        .o_tx_valid         (o_tx_valid),
        .i_tx_ready         (i_tx_ready),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    logic [31:0] mem [16];

    always @(posedge i_clk) begin
        if (o_mem_r_en) i_mem_r_data <= mem[o_mem_r_addr[5:2]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_bytes[$];
    logic [5:0] got_addrs[$];
    logic [7:0] exp_bytes[$];
    logic [5:0] exp_addrs[$];
    int done_cnt, done_n, first_req_n, first_valid_n;
    int stable_err, busy_err;

    function automatic void build_model(input logic [5:0] base,
                                        input logic [4:0] cnt);
        logic [5:0]  a;
        logic [7:0]  x;
        logic [31:0] w;
        exp_bytes.delete();
        exp_addrs.delete();
        a = base & 6'h3C;
        x = 8'h00;
        for (int i = 0; i < int'(cnt); i++) begin
            exp_addrs.push_back(a);
            w = mem[a[5:2]];
            for (int b = 3; b >= 0; b--) begin
                exp_bytes.push_back(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
            a = a + 6'd4;
        end
        if (CSUM_EN != 0) exp_bytes.push_back(x);
    endfunction

    // rmode: 0 ready always high, 1 pattern 1,0,0 repeating, 2 random
    task automatic run_dump(input logic [5:0] base, input logic [4:0] cnt,
                            input int rmode, input bit poke);
        logic       pv, pr, r;
        logic [7:0] pd;
        int         n, extra, tog;
        bit         seen_done, poked;
        got_bytes.delete();
        got_addrs.delete();
        done_cnt = 0; done_n = -1; first_req_n = -1; first_valid_n = -1;
        stable_err = 0; busy_err = 0;
        @(negedge i_clk);
        i_base_addr  = base;
        i_word_count = cnt;
        i_start      = 1'b1;
        @(posedge i_clk);
        n = 0; extra = 0; tog = 0; seen_done = 0; poked = 0;
        pv = 0; pr = 0; pd = 0;
        while (extra < 3 && n < LIMIT) begin
            @(negedge i_clk);
            n++;
            i_start = 1'b0;
            if (seen_done) extra++;
            if (o_mem_r_en) begin
                got_addrs.push_back(o_mem_r_addr);
                if (first_req_n < 0) first_req_n = n;
            end
            if (o_done) begin
                done_cnt++;
                done_n = n;
                seen_done = 1;
            end
            if (o_busy !== (!seen_done || n == done_n)) busy_err++;
            if (pv && !pr && (o_tx_valid !== 1'b1 || o_tx_data !== pd))
                stable_err++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = (tog % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tog++;
            i_tx_ready = r;
            if (o_tx_valid && first_valid_n < 0) first_valid_n = n;
            if (o_tx_valid && r) got_bytes.push_back(o_tx_data);
            if (poke && o_tx_valid && !poked) begin
                i_start      = 1'b1;
                i_base_addr  = ~base;
                i_word_count = cnt + 5'd3;
                poked        = 1;
            end
            pv = o_tx_valid;
            pr = r;
            pd = o_tx_data;
        end
        i_tx_ready = 1'b0;
        n_checks++;
        if (n >= LIMIT) begin
            n_fail++;
            $display("FAIL dump_timeout: ran %0d cycles, required done within %0d", n, LIMIT);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks += 6;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy);
        end
        if (o_tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", o_tx_valid);
        end
        if (o_mem_r_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_r_en: got %b expected 0", o_mem_r_en);
        end
        if (o_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", o_done);
        end
        if (o_tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00", o_tx_data);
        end
        if (o_mem_r_addressing !== 2'b00) begin
            n_fail++; $display("FAIL reset_addressing: got %b expected 00", o_mem_r_addressing);
        end
    endtask

    task automatic test_single_word();
        mem[0] = 32'h0123abcd;
        run_dump(6'h00, 5'd1, 0, 0);
        build_model(6'h00, 5'd1);
        n_checks += 6;
        if (first_req_n !== 1 || got_addrs.size() !== 1) begin
            n_fail++;
            $display("FAIL single_req: got cycle %0d count %0d expected cycle 1 count 1",
                     first_req_n, got_addrs.size());
        end else if (got_addrs[0] !== 6'h00) begin
            n_fail++; $display("FAIL single_addr: got %h expected 00", got_addrs[0]);
        end
        if (first_valid_n !== 3) begin
            n_fail++; $display("FAIL single_latency: got %0d expected 3", first_valid_n);
        end
        if (done_n !== 7 + CSUM_EN || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_done: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     done_n, done_cnt, 7 + CSUM_EN);
        end
        if (got_bytes.size() !== exp_bytes.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                n_checks++;
                if (got_bytes[i] !== exp_bytes[i]) begin
                    n_fail++;
                    $display("FAIL single_byte%0d: got %h expected %h", i, got_bytes[i], exp_bytes[i]);
                end
            end
        end
        if (got_bytes.size() < 1 || got_bytes[0] !== 8'h01) begin
            n_fail++; $display("FAIL single_first_byte: expected 01");
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        n_checks++;
        if (got_bytes.size() != 5 || got_bytes[4] !== 8'h44) begin
            n_fail++; $display("FAIL single_csum: expected 5th byte 44");
        end
`endif
        if (busy_err !== 0) begin
            n_fail++; $display("FAIL single_busy: got %0d bad cycles expected 0", busy_err);
        end
    endtask

    task automatic test_backpressure();
        mem[0] = 32'h0123abcd;
        run_dump(6'h00, 5'd1, 1, 0);
        build_model(6'h00, 5'd1);
        n_checks += 3;
        if (stable_err !== 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err);
        end
        if (done_cnt !== 1) begin
            n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt);
        end
        if (got_bytes.size() !== exp_bytes.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                n_checks++;
                if (got_bytes[i] !== exp_bytes[i]) begin
                    n_fail++;
                    $display("FAIL bp_byte%0d: got %h expected %h", i, got_bytes[i], exp_bytes[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        run_dump(6'h3A, 5'd3, 0, 0);
        build_model(6'h3A, 5'd3);
        n_checks += 3;
        if (got_addrs.size() !== 3) begin
            n_fail++; $display("FAIL wrap_reads: got %0d expected 3", got_addrs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_addrs[i] !== exp_addrs[i]) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d: got %h expected %h", i, got_addrs[i], exp_addrs[i]);
                end
            end
        end
        if (done_cnt !== 1 || done_n !== 19 + CSUM_EN) begin
            n_fail++;
            $display("FAIL wrap_done: got pulses %0d cycle %0d expected 1 at %0d",
                     done_cnt, done_n, 19 + CSUM_EN);
        end
        if (got_bytes != exp_bytes) begin
            n_fail++;
            $display("FAIL wrap_bytes: got %0d bytes expected %0d matching model",
                     got_bytes.size(), exp_bytes.size());
        end
    endtask

    task automatic test_zero_count();
        run_dump(6'h10, 5'd0, 0, 0);
        n_checks += 3;
        if (done_n !== 1 + CSUM_EN || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_done: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     done_n, done_cnt, 1 + CSUM_EN);
        end
        if (got_addrs.size() !== 0) begin
            n_fail++; $display("FAIL zero_reads: got %0d expected 0", got_addrs.size());
        end
        if (got_bytes.size() !== CSUM_EN) begin
            n_fail++; $display("FAIL zero_bytes: got %0d expected %0d", got_bytes.size(), CSUM_EN);
        end else if (CSUM_EN != 0 && got_bytes[0] !== 8'h00) begin
            n_fail++; $display("FAIL zero_csum: got %h expected 00", got_bytes[0]);
        end
    endtask

    task automatic test_ignored_start();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        run_dump(6'h08, 5'd2, 0, 1);
        build_model(6'h08, 5'd2);
        n_checks += 3;
        if (got_bytes != exp_bytes) begin
            n_fail++;
            $display("FAIL ign_bytes: got %0d bytes expected %0d matching model",
                     got_bytes.size(), exp_bytes.size());
        end
        if (got_addrs != exp_addrs) begin
            n_fail++; $display("FAIL ign_reads: got %0d reads expected %0d", got_addrs.size(), exp_addrs.size());
        end
        if (done_cnt !== 1 || done_n !== 13 + CSUM_EN) begin
            n_fail++;
            $display("FAIL ign_done: got pulses %0d cycle %0d expected 1 at %0d",
                     done_cnt, done_n, 13 + CSUM_EN);
        end
    endtask

    task automatic test_reset_mid_dump();
        @(negedge i_clk);
        i_base_addr  = 6'h00;
        i_word_count = 5'd4;
        i_start      = 1'b1;
        i_tx_ready   = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got %b expected 0", o_busy);
        end
        if (o_tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b expected 0", o_tx_valid);
        end
        if (o_mem_r_en !== 1'b0 || o_done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ctl: got r_en %b done %b expected 0 0", o_mem_r_en, o_done);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mem[1] = 32'hcafe0042;
        run_dump(6'h04, 5'd1, 0, 0);
        build_model(6'h04, 5'd1);
        n_checks++;
        if (got_bytes != exp_bytes || done_n !== 7 + CSUM_EN) begin
            n_fail++;
            $display("FAIL midrst_resume: got %0d bytes done at %0d expected %0d bytes done at %0d",
                     got_bytes.size(), done_n, exp_bytes.size(), 7 + CSUM_EN);
        end
    endtask

    task automatic test_random();
        logic [5:0] base;
        logic [4:0] cnt;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            base = 6'($urandom_range(0, 63));
            cnt  = 5'($urandom_range(0, 6));
            run_dump(base, cnt, 2, 0);
            build_model(base, cnt);
            n_checks += 4;
            if (got_bytes != exp_bytes) begin
                n_fail++;
                $display("FAIL rand%0d_bytes: got %0d bytes expected %0d matching model",
                         it, got_bytes.size(), exp_bytes.size());
            end
            if (got_addrs != exp_addrs) begin
                n_fail++;
                $display("FAIL rand%0d_reads: got %0d reads expected %0d", it, got_addrs.size(), exp_addrs.size());
            end
            if (done_cnt !== 1) begin
                n_fail++; $display("FAIL rand%0d_done: got %0d pulses expected 1", it, done_cnt);
            end
            if (stable_err !== 0 || busy_err !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_proto: got unstable %0d busy %0d expected 0 0", it, stable_err, busy_err);
            end
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_base_addr  = '0;
        i_word_count = '0;
        i_tx_ready   = 1'b0;
        i_mem_r_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_ignored_start();
        test_reset_mid_dump();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
